// File: rtl/feedback_loop_decimator_if.sv
// Stream/bus bundle for feedback_loop_decimator.
//   in_sample  : signed 8-bit sample from the feedback loop
//   in_valid   : in_sample valid this cycle (never back-pressured)
//   out_sum    : signed 12-bit group sum at the FIFO head (0 when empty)
//   out_mean   : signed 8-bit floor mean of out_sum (0 when empty)
//   out_valid  : FIFO non-empty, head presented
//   out_ready  : consumer takes the head when out_valid=1
//   level      : FIFO occupancy
//   overflow   : sticky "a result was dropped" flag
// The master modport is the decimator's view; the slave modport is the
// view of whatever surrounds it (sample source plus result consumer).
interface feedback_loop_decimator_if;
  logic signed [7:0]  in_sample;
  logic               in_valid;
  logic signed [11:0] out_sum;
  logic signed [7:0]  out_mean;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         level;
  logic               overflow;

  modport master (
    input  in_sample, in_valid, out_ready,
    output out_sum, out_mean, out_valid, level, overflow
  );

  modport slave (
    output in_sample, in_valid, out_ready,
    input  out_sum, out_mean, out_valid, level, overflow
  );
endinterface

// File: rtl/feedback_loop_decimator.sv
// feedback_loop_decimator
// Sums DECIM consecutive accepted signed samples and queues each sum in a
// small show-ahead FIFO drained by a valid/ready consumer. The head entry
// is presented both as the raw sum and as the floor mean (sum >>> LOG2_DECIM).
// Ports:
//   system1000      : clock, all state updates on the rising edge
//   system1000_rst  : synchronous active-high reset
//   bus             : feedback_loop_decimator_if.master (sample in, result out,
//                     level, sticky overflow)
module feedback_loop_decimator #(
  parameter int DECIM      = 4,
  parameter int LOG2_DECIM = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic                         system1000,
  input logic                         system1000_rst,
  feedback_loop_decimator_if.master   bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Accumulator
  logic signed [11:0] acc_reg, acc_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic signed [11:0] sample_ext;
  logic signed [11:0] result;
  logic               group_done;

  assign sample_ext = {{4{bus.in_sample[7]}}, bus.in_sample};
  assign result     = acc_reg + sample_ext;
  assign group_done = bus.in_valid && (cnt_reg == 4'(DECIM - 1));

  always_comb begin
    acc_next = acc_reg;
    cnt_next = cnt_reg;
    if (group_done) begin
      acc_next = '0;
      cnt_next = '0;
    end else if (bus.in_valid) begin
      acc_next = result;
      cnt_next = cnt_reg + 4'd1;
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
    end
  end

  // Result FIFO
  logic signed [11:0] mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [3:0]         level_reg, level_next;
  logic               overflow_reg;
  logic               not_empty, full, pop, write_en;
  logic signed [11:0] head;

  assign not_empty = (level_reg != 4'd0);
  assign full      = (level_reg == 4'(FIFO_DEPTH));
  assign pop       = not_empty && bus.out_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign write_en  = group_done && (!full || pop);

  always_comb begin
    level_next = level_reg;
    case ({write_en, pop})
      2'b10:   level_next = level_reg + 4'd1;
      2'b01:   level_next = level_reg - 4'd1;
      default: level_next = level_reg;
    endcase
  end

  // Storage is not reset; entries are only visible through level.
  always_ff @(posedge system1000) begin
    if (write_en) begin
      mem_reg[wr_ptr_reg] <= result;
    end
  end

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      level_reg <= level_next;
      // Pointers are log2(FIFO_DEPTH) wide so they wrap naturally.
      if (write_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)      rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (group_done && full && !pop) overflow_reg <= 1'b1;
    end
  end

  // Show-ahead head; outputs forced to zero while empty.
  assign head          = mem_reg[rd_ptr_reg];
  assign bus.out_valid = not_empty;
  assign bus.out_sum   = not_empty ? head : 12'sd0;
  assign bus.out_mean  = not_empty ? 8'(head >>> LOG2_DECIM) : 8'sd0;
  assign bus.level     = level_reg;
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_feedback_loop_decimator.sv
module tb_feedback_loop_decimator;

  localparam int DECIM = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  feedback_loop_decimator_if ifc ();

  feedback_loop_decimator #(
    .DECIM(DECIM), .LOG2_DECIM(2), .FIFO_DEPTH(DEPTH)
  ) dut (
    .system1000(clk),
    .system1000_rst(rst),
    .bus(ifc.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a list of completed sums, a running group tally.
  int  q[$];
  int  grp_sum = 0;
  int  grp_n   = 0;
  bit  ovf     = 0;
  bit  live    = 0;

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        grp_sum = 0;
        grp_n   = 0;
        ovf     = 0;
        live    = 1;
      end else begin
        bit pop_now;
        bit push_now;
        int res;
        pop_now  = (q.size() > 0) && ifc.out_ready;
        push_now = 0;
        res      = 0;
        if (ifc.in_valid) begin
          grp_sum += int'(ifc.in_sample);
          grp_n++;
          if (grp_n == DECIM) begin
            push_now = 1;
            res      = grp_sum;
            grp_sum  = 0;
            grp_n    = 0;
          end
        end
        if (pop_now) void'(q.pop_front());
        if (push_now) begin
          if (q.size() < DEPTH) q.push_back(res);
          else ovf = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (live) begin
        int exp_sum;
        exp_sum = (q.size() > 0) ? q[0] : 0;
        chk("valid", int'(ifc.out_valid), int'(q.size() > 0));
        chk("sum", int'(ifc.out_sum), exp_sum);
        chk("mean", int'(ifc.out_mean), (q.size() > 0) ? floor_div(exp_sum, DECIM) : 0);
        chk("level", int'(ifc.level), q.size());
        chk("overflow", int'(ifc.overflow), int'(ovf));
      end
    end
  end

  // Apply inputs for one edge and return at the following falling edge.
  task automatic drive(input logic rs, input logic v, input int s, input logic r);
    rst           = rs;
    ifc.in_valid  = v;
    ifc.in_sample = 8'(s);
    ifc.out_ready = r;
    @(negedge clk);
    $display("cyc t=%0t rst=%0d v=%0d s=%0d r=%0d -> ov=%0d sum=%0d mean=%0d lvl=%0d ovf=%0d",
             $time, rs, v, s, r, ifc.out_valid, ifc.out_sum, ifc.out_mean, ifc.level, ifc.overflow);
  endtask

  task automatic group4(input int a, input int b, input int c, input int d, input logic r);
    drive(0, 1, a, r);
    drive(0, 1, b, r);
    drive(0, 1, c, r);
    drive(0, 1, d, r);
  endtask

  initial begin
    int ready_pct;
    ifc.in_valid  = 0;
    ifc.in_sample = 0;
    ifc.out_ready = 0;

    // Reset state
    drive(1, 1, 9, 1);
    chk("rst_valid", int'(ifc.out_valid), 0);
    chk("rst_level", int'(ifc.level), 0);
    chk("rst_ovf", int'(ifc.overflow), 0);

    // 1: 1,2,3,4 -> one-cycle result 10 / 2
    drive(0, 1, 1, 1);
    drive(0, 1, 2, 1);
    drive(0, 1, 3, 1);
    chk("t1_not_yet", int'(ifc.out_valid), 0);
    drive(0, 1, 4, 1);
    chk("t1_valid", int'(ifc.out_valid), 1);
    chk("t1_sum", int'(ifc.out_sum), 10);
    chk("t1_mean", int'(ifc.out_mean), 2);
    drive(0, 0, 0, 1);
    chk("t1_gone", int'(ifc.out_valid), 0);
    chk("t1_level", int'(ifc.level), 0);

    // 2: extremes and floor of negative mean
    group4(-128, -128, -128, -128, 1);
    chk("t2a_sum", int'(ifc.out_sum), -512);
    chk("t2a_mean", int'(ifc.out_mean), -128);
    group4(127, 127, 127, 127, 1);
    chk("t2b_sum", int'(ifc.out_sum), 508);
    chk("t2b_mean", int'(ifc.out_mean), 127);
    group4(-1, -1, -1, 0, 1);
    chk("t2c_sum", int'(ifc.out_sum), -3);
    chk("t2c_mean", int'(ifc.out_mean), -1);
    drive(0, 0, 0, 1);

    // 3: gaps do not break a group
    drive(0, 1, 5, 1);
    drive(0, 0, 5, 1);
    drive(0, 0, 5, 1);
    drive(0, 1, 5, 1);
    drive(0, 1, 5, 1);
    drive(0, 0, 5, 1);
    chk("t3_not_yet", int'(ifc.out_valid), 0);
    drive(0, 1, 5, 1);
    chk("t3_valid", int'(ifc.out_valid), 1);
    chk("t3_sum", int'(ifc.out_sum), 20);
    drive(0, 0, 0, 1);

    // 4: overflow on a full FIFO, then drain
    for (int g = 0; g < 4; g++) group4(1, 1, 1, 1, 0);
    chk("t4_full", int'(ifc.level), 4);
    chk("t4_ovf0", int'(ifc.overflow), 0);
    group4(1, 1, 1, 1, 0);
    chk("t4_level", int'(ifc.level), 4);
    chk("t4_ovf1", int'(ifc.overflow), 1);
    for (int k = 0; k < 4; k++) begin
      chk("t4_drain_sum", int'(ifc.out_sum), 4);
      drive(0, 0, 0, 1);
    end
    chk("t4_empty", int'(ifc.out_valid), 0);
    chk("t4_sticky", int'(ifc.overflow), 1);

    // 5: push and pop together while full
    drive(1, 0, 0, 0);
    for (int g = 1; g <= 4; g++) group4(g, g, g, g, 0);
    chk("t5_full", int'(ifc.level), 4);
    drive(0, 1, 5, 0);
    drive(0, 1, 5, 0);
    drive(0, 1, 5, 0);
    drive(0, 1, 5, 1);
    chk("t5_level", int'(ifc.level), 4);
    chk("t5_ovf", int'(ifc.overflow), 0);
    for (int k = 2; k <= 5; k++) begin
      chk("t5_order", int'(ifc.out_sum), 4 * k);
      drive(0, 0, 0, 1);
    end
    chk("t5_empty", int'(ifc.out_valid), 0);

    // 6: reset discards partial sum and queued entries
    group4(1, 1, 1, 1, 0);
    group4(1, 1, 1, 1, 0);
    drive(0, 1, 9, 0);
    drive(0, 1, 9, 0);
    chk("t6_pre_level", int'(ifc.level), 2);
    drive(1, 1, 9, 1);
    chk("t6_valid", int'(ifc.out_valid), 0);
    chk("t6_sum", int'(ifc.out_sum), 0);
    chk("t6_mean", int'(ifc.out_mean), 0);
    chk("t6_level", int'(ifc.level), 0);
    group4(2, 2, 2, 2, 0);
    chk("t6_sum8", int'(ifc.out_sum), 8);
    chk("t6_level1", int'(ifc.level), 1);

    // Randomized phase with varying drain pressure and rare resets
    ready_pct = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) ready_pct = (i / 400) % 3 == 0 ? 10 : ((i / 400) % 3 == 1 ? 90 : 45);
      drive(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 99) < 80),
            int'($urandom_range(0, 255)) - 128,
            ($urandom_range(0, 99) < ready_pct));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/feedback_loop_decimator.md
Name: feedback_loop_decimator

Overview:
Downstream stage of the feedback loop top entity. Consumes its signed 8-bit sample stream, sums DECIM consecutive accepted samples, and pushes each sum into a small show-ahead FIFO. The FIFO is drained by a valid/ready consumer (e.g. a UART/packet framer). Both the raw sum and the mean (sum arithmetically shifted right) are presented.

Parameters:
DECIM, 4, samples per output; power of two, range 2..16.
LOG2_DECIM, 2, log2(DECIM); must be consistent with DECIM.
FIFO_DEPTH, 4, result FIFO entries; power of two, range 2..8.

Ports:
system1000  in  1  clock; all state updates on rising edge.
system1000_rst  in  1  synchronous reset, active-high.
in_sample  in  8  signed sample from the feedback loop output.
in_valid  in  1  in_sample is valid this cycle; no backpressure, always accepted.
out_sum  out  12  signed sum of DECIM samples, sign-extended; 0 when out_valid=0.
out_mean  out  8  signed out_sum >>> LOG2_DECIM (floor); 0 when out_valid=0.
out_valid  out  1  FIFO non-empty; head entry presented.
out_ready  in  1  consumer accepts head when out_valid=1.
level  out  4  current FIFO occupancy, 0..FIFO_DEPTH.
overflow  out  1  sticky flag; set when a result is dropped.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high. Clock is system1000, reset is system1000_rst.
- Reset: the following are cleared to 0 on the first edge with system1000_rst=1, regardless of other inputs:
  - acc, cnt
  - FIFO pointers, level
  - out_valid, out_sum, out_mean
  - overflow
- Reset mid-group discards the partial sum. Reset while the FIFO is non-empty discards all entries.
- Accumulation:
  - acc is 12-bit signed; cnt is a 4-bit counter.
  - On an edge with in_valid=1 and cnt<DECIM-1: acc <= acc + sext(in_sample); cnt <= cnt+1.
  - On in_valid=1 and cnt==DECIM-1: result = acc + sext(in_sample). result is pushed to the FIFO; acc <= 0; cnt <= 0.
  - in_valid=0: acc and cnt hold. Gaps do not break a group.
  - No overflow is possible in acc: range is -2048..2032 for DECIM=16.
- FIFO:
  - Show-ahead; out_sum and out_mean are derived combinationally from the registered head entry.
  - out_valid = (level != 0).
  - pop = out_valid & out_ready.
  - push occurs on a group-complete edge.
- Push/pop cases:
  - push only, level<FIFO_DEPTH: write, level+1.
  - push only, level==FIFO_DEPTH: result dropped, overflow <= 1, FIFO unchanged.
  - push and pop in the same cycle, any level including full: both happen; level unchanged; no drop.
  - pop only: level-1.
  - out_ready while out_valid=0: ignored.
- Latency:
  - A result appears on out_sum/out_valid the cycle after the edge that accepted the DECIM-th sample, when the FIFO was empty.
  - Otherwise it appears after the entries ahead of it are popped.
- Pointers wrap modulo FIFO_DEPTH.
- Mean: arithmetic right shift, i.e. floor toward -inf. Always fits 8 bits signed.
- overflow clears only on reset.

Test Plan:
1. DECIM=4, out_ready=1; samples 1,2,3,4 on consecutive cycles -> out_valid=1 for exactly 1 cycle starting the cycle after sample 4; out_sum=10, out_mean=2; then level=0.
2. Groups (-128×4), (127×4), (-1,-1,-1,0) -> out_sum=-512/508/-3 and out_mean=-128/127/-1 (floor check).
3. in_valid pattern 1,0,0,1,1,0,1 with sample=5 -> single result out_sum=20, emitted the cycle after the 4th valid sample.
4. FIFO_DEPTH=4, out_ready=0; five groups of (1,1,1,1):
   - level=4 after the fourth group; fifth result dropped; overflow=1.
   - Then out_ready=1 -> four results of sum 4, then out_valid=0; overflow remains 1.
5. level=4 with out_ready=1 held during the push cycle -> push accepted, level stays 4, overflow stays 0; drain yields all results in order.
6. After two samples of 9, assert system1000_rst one cycle (also with FIFO holding 2 entries):
   - All outputs read 0.
   - Subsequent samples 2,2,2,2 -> out_sum=8 with no contribution from the 9s.
